// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encodings, cause codes and field positions for the machine-mode CSR/trap unit.
package csr_pkg;
   typedef enum logic [1:0] {
      OP_ILL = 2'b00,
      OP_RW  = 2'b01,
      OP_RS  = 2'b10,
      OP_RC  = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_MSI     = 4'd3;
   localparam logic [3:0] CAUSE_MTI     = 4'd7;
   localparam logic [3:0] CAUSE_MEI     = 4'd11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;
   localparam logic [31:0] MIE_MASK = 32'h0000_0888;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wdata);
      case (op)
         OP_RW:   return wdata;
         OP_RS:   return old | wdata;
         OP_RC:   return old & ~wdata;
         default: return old;
      endcase
   endfunction
endpackage

// File: rtl/csr_counter.sv
// Up-to-64-bit event counter with 32-bit half writes; a half write replaces that cycle's increment.
// Bits above W read as zero; the count wraps from all-ones to zero.
module csr_counter #(
   parameter int W = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_lo,
   output logic [31:0] o_hi
);
   logic [W-1:0] r_cnt;
   logic [63:0]  w_cur;
   logic [63:0]  w_next;

   assign w_cur = 64'(r_cnt);

   always_comb begin
      w_next = w_cur;
      if (i_wr_lo || i_wr_hi) begin
         if (i_wr_lo) w_next[31:0]  = i_wdata;
         if (i_wr_hi) w_next[63:32] = i_wdata;
      end else if (i_inc) begin
         w_next = w_cur + 64'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_cnt <= '0;
      else       r_cnt <= w_next[W-1:0];
   end

   assign o_lo = w_cur[31:0];
   assign o_hi = w_cur[63:32];
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/MRET sequencing; CSR reads are combinational, redirect is
// registered one cycle after the trap or MRET commits. Priority: exception > interrupt > MRET > CSR write.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          COUNTER_W   = 64,
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter bit          VECTORED_EN = 1'b1,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        csr_valid_i,
   input  logic [1:0]  csr_op_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic        csr_rs1_zero_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_illegal_o,
   input  logic        exc_valid_i,
   input  logic [3:0]  exc_cause_i,
   input  logic [31:0] exc_pc_i,
   input  logic [31:0] exc_tval_i,
   input  logic        irq_take_i,
   input  logic        mret_i,
   input  logic        instret_i,
   input  logic        irq_meip_i,
   input  logic        irq_mtip_i,
   input  logic        irq_msip_i,
   output logic        irq_pending_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o
);
   logic        r_mie_bit, r_mpie, r_mcause_irq, r_redirect;
   logic [3:0]  r_mcause_code;
   logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mtval, r_redirect_pc;

   logic [31:0] w_mip, w_mstatus, w_rdata, w_new, w_base, w_vec_pc;
   logic [31:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;
   logic        w_known, w_ro, w_wr_intent, w_illegal, w_pending, w_irq_trap, w_mret, w_csr_wr;
   logic [3:0]  w_irq_code;
   csr_op_e     w_op;

   assign w_op      = csr_op_e'(csr_op_i);
   assign w_mip     = {20'b0, irq_meip_i, 3'b0, irq_mtip_i, 3'b0, irq_msip_i, 3'b0};
   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie_bit, 3'b0};

   always_comb begin
      w_rdata = '0;
      w_known = 1'b1;
      w_ro    = 1'b0;
      case (csr_addr_i)
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_ro = 1'b1;
         CSR_MHARTID:   begin w_rdata = HART_ID;  w_ro = 1'b1; end
         CSR_MISA:      begin w_rdata = MISA_VAL; w_ro = 1'b1; end
         CSR_MIP:       begin w_rdata = w_mip;    w_ro = 1'b1; end
         CSR_MSTATUS:   w_rdata = w_mstatus;
         CSR_MIE:       w_rdata = r_mie;
         CSR_MTVEC:     w_rdata = r_mtvec;
         CSR_MSCRATCH:  w_rdata = r_mscratch;
         CSR_MEPC:      w_rdata = r_mepc;
         CSR_MCAUSE:    w_rdata = {r_mcause_irq, 27'b0, r_mcause_code};
         CSR_MTVAL:     w_rdata = r_mtval;
         CSR_MCYCLE:    w_rdata = w_cyc_lo;
         CSR_MCYCLEH:   w_rdata = w_cyc_hi;
         CSR_MINSTRET:  w_rdata = w_ins_lo;
         CSR_MINSTRETH: w_rdata = w_ins_hi;
         default:       w_known = 1'b0;
      endcase
   end

   assign w_wr_intent = (w_op == OP_RW) || !csr_rs1_zero_i;
   assign w_illegal   = csr_valid_i && (!w_known || w_op == OP_ILL || (w_ro && w_wr_intent));
   assign w_new       = csr_apply(w_op, w_rdata, csr_wdata_i);

   assign w_pending = r_mie_bit && |(r_mie & w_mip);

   always_comb begin
      if (r_mie[MIE_MEIE] && irq_meip_i)      w_irq_code = CAUSE_MEI;
      else if (r_mie[MIE_MSIE] && irq_msip_i) w_irq_code = CAUSE_MSI;
      else                                    w_irq_code = CAUSE_MTI;
   end

   // Lower-priority events are dropped entirely when a higher one fires in the same cycle.
   assign w_irq_trap = irq_take_i && w_pending && !exc_valid_i;
   assign w_mret     = mret_i && !exc_valid_i && !w_irq_trap;
   assign w_csr_wr   = csr_valid_i && !w_illegal && w_wr_intent && !exc_valid_i && !w_irq_trap && !mret_i;

   assign w_base   = {r_mtvec[31:2], 2'b00};
   assign w_vec_pc = (VECTORED_EN && r_mtvec[0]) ? w_base + {26'b0, w_irq_code, 2'b00} : w_base;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mie_bit     <= 1'b0;
         r_mpie        <= 1'b0;
         r_mie         <= '0;
         r_mtvec       <= {RESET_MTVEC[31:2], 1'b0, VECTORED_EN & RESET_MTVEC[0]};
         r_mscratch    <= '0;
         r_mepc        <= '0;
         r_mcause_irq  <= 1'b0;
         r_mcause_code <= '0;
         r_mtval       <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_redirect <= 1'b0;
         if (exc_valid_i) begin
            r_mepc        <= exc_pc_i & ~32'd3;
            r_mcause_irq  <= 1'b0;
            r_mcause_code <= exc_cause_i;
            r_mtval       <= exc_tval_i;
            r_mpie        <= r_mie_bit;
            r_mie_bit     <= 1'b0;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_base;
         end else if (w_irq_trap) begin
            r_mepc        <= exc_pc_i & ~32'd3;
            r_mcause_irq  <= 1'b1;
            r_mcause_code <= w_irq_code;
            r_mtval       <= '0;
            r_mpie        <= r_mie_bit;
            r_mie_bit     <= 1'b0;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_vec_pc;
         end else if (w_mret) begin
            r_mie_bit     <= r_mpie;
            r_mpie        <= 1'b1;
            r_redirect    <= 1'b1;
            r_redirect_pc <= r_mepc;
         end else if (w_csr_wr) begin
            case (csr_addr_i)
               CSR_MSTATUS: begin
                  r_mie_bit <= w_new[MSTATUS_MIE];
                  r_mpie    <= w_new[MSTATUS_MPIE];
               end
               CSR_MIE:      r_mie      <= w_new & MIE_MASK;
               CSR_MTVEC:    r_mtvec    <= {w_new[31:2], 1'b0, VECTORED_EN & w_new[0]};
               CSR_MSCRATCH: r_mscratch <= w_new;
               CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
               CSR_MCAUSE: begin
                  r_mcause_irq  <= w_new[31];
                  r_mcause_code <= w_new[3:0];
               end
               CSR_MTVAL:    r_mtval    <= w_new;
               default: ;
            endcase
         end
      end
   end

   csr_counter #(.W(COUNTER_W)) u_mcycle (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_inc   (1'b1),
      .i_wr_lo (w_csr_wr && csr_addr_i == CSR_MCYCLE),
      .i_wr_hi (w_csr_wr && csr_addr_i == CSR_MCYCLEH),
      .i_wdata (w_new),
      .o_lo    (w_cyc_lo),
      .o_hi    (w_cyc_hi)
   );

   csr_counter #(.W(COUNTER_W)) u_minstret (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_inc   (instret_i),
      .i_wr_lo (w_csr_wr && csr_addr_i == CSR_MINSTRET),
      .i_wr_hi (w_csr_wr && csr_addr_i == CSR_MINSTRETH),
      .i_wdata (w_new),
      .o_lo    (w_ins_lo),
      .o_hi    (w_ins_hi)
   );

   assign csr_rdata_o   = w_rdata;
   assign csr_illegal_o = w_illegal;
   assign irq_pending_o = w_pending;
   assign redirect_o    = r_redirect;
   assign redirect_pc_o = r_redirect_pc;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus queues expected read/redirect results, a negedge monitor checks them.
module tb_csr_trap_unit;
   import csr_pkg::*;

   localparam logic [31:0] HART = 32'd5;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        csr_valid_i, csr_rs1_zero_i, exc_valid_i, irq_take_i, mret_i, instret_i;
   logic        irq_meip_i, irq_mtip_i, irq_msip_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i, exc_pc_i, exc_tval_i;
   logic [3:0]  exc_cause_i;
   logic [31:0] csr_rdata_o, redirect_pc_o;
   logic        csr_illegal_o, irq_pending_o, redirect_o;

   csr_trap_unit #(.COUNTER_W(64), .HART_ID(HART), .VECTORED_EN(1'b1), .RESET_MTVEC(32'h100)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i),
      .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rs1_zero_i(csr_rs1_zero_i),
      .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o), .exc_valid_i(exc_valid_i),
      .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
      .irq_take_i(irq_take_i), .mret_i(mret_i), .instret_i(instret_i),
      .irq_meip_i(irq_meip_i), .irq_mtip_i(irq_mtip_i), .irq_msip_i(irq_msip_i),
      .irq_pending_o(irq_pending_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          id;
      logic [31:0] rd;
      logic        chk_rd;
      logic        ill;
      logic        chk_pend;
      logic        pend;
   } rd_exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
   } redir_exp_t;

   rd_exp_t    rdq[$];
   redir_exp_t rq[$];
   rd_exp_t    me;
   redir_exp_t mr;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rel = 0;
   int         nid = 0;

   always @(posedge clk_i) cyc = cyc + 1;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s #%0d: got %h, expected %h", nm, id, act, exp);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the head of the matching queue.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (csr_valid_i) begin
            if (rdq.size() == 0) begin
               chk("rd_queue_nonempty", -1, 32'(rdq.size()), 32'd1);
            end else begin
               me = rdq.pop_front();
               if (me.chk_rd) chk("rdata", me.id, csr_rdata_o, me.rd);
               chk("illegal", me.id, {31'b0, csr_illegal_o}, {31'b0, me.ill});
               if (me.chk_pend) chk("pending", me.id, {31'b0, irq_pending_o}, {31'b0, me.pend});
            end
         end
         if (redirect_o) begin
            if (rq.size() == 0) begin
               chk("redir_queue_nonempty", cyc, 32'(rq.size()), 32'd1);
            end else begin
               mr = rq.pop_front();
               chk("redir_pc", mr.cyc, redirect_pc_o, mr.pc);
               chk("redir_cycle", mr.cyc, 32'(cyc), 32'(mr.cyc));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      csr_valid_i = 1'b0; csr_op_i = 2'b00; csr_rs1_zero_i = 1'b0;
      exc_valid_i = 1'b0; irq_take_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
   endtask

   task automatic csr_acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic rs1z, input logic [31:0] exp_rd, input logic chk_rd,
                          input logic exp_ill, input logic chk_pend, input logic exp_pend);
      rd_exp_t e;
      csr_valid_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd; csr_rs1_zero_i = rs1z;
      e.id = nid; e.rd = exp_rd; e.chk_rd = chk_rd; e.ill = exp_ill;
      e.chk_pend = chk_pend; e.pend = exp_pend;
      nid = nid + 1;
      rdq.push_back(e);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp);
      csr_acc(2'b10, a, 32'h0, 1'b1, exp, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic rdp(input logic [11:0] a, input logic [31:0] exp, input logic pend);
      csr_acc(2'b10, a, 32'h0, 1'b1, exp, 1'b1, 1'b0, 1'b1, pend);
      step();
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [31:0] old);
      csr_acc(op, a, wd, 1'b0, old, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic exp_redir(input logic [31:0] pc);
      redir_exp_t r;
      r.cyc = cyc + 1;
      r.pc  = pc;
      rq.push_back(r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; csr_valid_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0; csr_rs1_zero_i = 0;
      exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0; irq_take_i = 0; mret_i = 0;
      instret_i = 0; irq_meip_i = 0; irq_mtip_i = 0; irq_msip_i = 0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      rel = cyc;
      chk("reset_redirect", 0, {31'b0, redirect_o}, 32'd0);
      chk("reset_redirect_pc", 0, redirect_pc_o, 32'd0);

      // Reset values
      rd(CSR_MSTATUS, 32'h0000_1800);
      rd(CSR_MTVEC, 32'h0000_0100);
      rd(CSR_MHARTID, HART);
      rd(CSR_MISA, 32'h4000_0100);
      rd(CSR_MIE, 32'h0);
      rd(CSR_MCAUSE, 32'h0);
      rd(CSR_MCYCLEH, 32'h0);
      while ((cyc - rel) < 10) step();
      rd(CSR_MCYCLE, 32'd10);

      // Timer interrupt through vectored mtvec
      wr(2'b10, CSR_MIE, 32'h888, 32'h0);
      wr(2'b10, CSR_MSTATUS, 32'h8, 32'h1800);
      wr(2'b01, CSR_MTVEC, 32'h301, 32'h100);
      irq_mtip_i = 1'b1;
      rdp(CSR_MIP, 32'h80, 1'b1);
      irq_take_i = 1'b1; exc_pc_i = 32'h2004;
      exp_redir(32'h31C);
      step();
      irq_mtip_i = 1'b0;
      rdp(CSR_MCAUSE, 32'h8000_0007, 1'b0);
      rd(CSR_MEPC, 32'h2004);
      rd(CSR_MSTATUS, 32'h1880);

      // All three lines: external wins, then MRET
      wr(2'b10, CSR_MSTATUS, 32'h8, 32'h1880);
      irq_meip_i = 1'b1; irq_msip_i = 1'b1; irq_mtip_i = 1'b1;
      rdp(CSR_MIP, 32'h888, 1'b1);
      irq_take_i = 1'b1; exc_pc_i = 32'h3000;
      exp_redir(32'h32C);
      step();
      irq_meip_i = 1'b0; irq_msip_i = 1'b0; irq_mtip_i = 1'b0;
      rd(CSR_MCAUSE, 32'h8000_000B);
      rd(CSR_MEPC, 32'h3000);
      rd(CSR_MSTATUS, 32'h1880);
      mret_i = 1'b1;
      exp_redir(32'h3000);
      step();
      rd(CSR_MSTATUS, 32'h1888);

      // Exception beats interrupt and CSR write in the same cycle
      irq_mtip_i = 1'b1;
      wr(2'b01, CSR_MSCRATCH, 32'h1234, 32'h0);
      csr_acc(2'b01, CSR_MSCRATCH, 32'h5555, 1'b0, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
      exc_valid_i = 1'b1; exc_cause_i = CAUSE_ILLEGAL; exc_tval_i = 32'hDEAD; exc_pc_i = 32'h4008;
      irq_take_i = 1'b1;
      exp_redir(32'h300);
      step();
      irq_mtip_i = 1'b0;
      rd(CSR_MSCRATCH, 32'h1234);
      rd(CSR_MCAUSE, 32'h2);
      rd(CSR_MTVAL, 32'hDEAD);
      rd(CSR_MEPC, 32'h4008);
      rd(CSR_MSTATUS, 32'h1880);

      // Counter wrap and write-over-increment
      wr(2'b01, CSR_MCYCLE, 32'hFFFF_FFFF, 32'(cyc - rel));
      wr(2'b01, CSR_MCYCLEH, 32'hFFFF_FFFF, 32'h0);
      step();
      rd(CSR_MCYCLE, 32'h0);
      rd(CSR_MCYCLEH, 32'h0);
      instret_i = 1'b1;
      wr(2'b01, CSR_MINSTRET, 32'h77, 32'h0);
      rd(CSR_MINSTRET, 32'h77);
      instret_i = 1'b1;
      step();
      rd(CSR_MINSTRET, 32'h78);
      rd(CSR_MINSTRETH, 32'h0);

      // Illegal accesses leave state untouched
      csr_acc(2'b01, CSR_MHARTID, 32'h1, 1'b0, HART, 1'b1, 1'b1, 1'b0, 1'b0); step();
      csr_acc(2'b10, 12'h7C0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      csr_acc(2'b00, CSR_MSCRATCH, 32'h9999, 1'b0, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0); step();
      csr_acc(2'b01, CSR_MIP, 32'hFFF, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); step();
      rd(CSR_MSCRATCH, 32'h1234);
      rd(CSR_MHARTID, HART);

      // WARL fields and clear-bits
      wr(2'b01, CSR_MEPC, 32'h1237, 32'h4008);
      rd(CSR_MEPC, 32'h1234);
      wr(2'b01, CSR_MTVEC, 32'h303, 32'h301);
      rd(CSR_MTVEC, 32'h301);
      wr(2'b11, CSR_MIE, 32'h80, 32'h888);
      rd(CSR_MIE, 32'h808);

      repeat (3) step();
      chk("rd_queue_drained", 0, 32'(rdq.size()), 32'd0);
      chk("redir_queue_drained", 0, 32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
